det_req_arbiter: RTL and testbench
==================================

Name: det_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4x4 determinant engine between NUM_REQ requesters.
- The engine uses a start/done handshake: signed 8-bit elements in, signed 16-bit result out.
- The block latches the winning requester's matrix, pulses the engine start, and waits for done, with a timeout.
- It then returns the result to the owning requester and advances the priority pointer.
- It sits between the coprocessor's command front-ends and the single determinant datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 64, maximum cycles in WAIT before aborting (>=8).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; held high until matching gnt pulse.
- mat_in  input  NUM_REQ*128  per-requester matrix; requester r occupies bits [r*128+127 : r*128].
- gnt  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
- eng_start  output  1  one-cycle start pulse to determinant engine.
- eng_mat  output  128  registered matrix to engine, stable from gnt cycle until return to IDLE.
- eng_done  input  1  engine completion pulse.
- eng_result  input  16  signed engine result, valid with eng_done.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse to owner.
- rsp_data  output  16  signed result, valid with rsp_valid.
- rsp_err  output  1  1 = timeout abort, valid with rsp_valid.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Matrix packing: each 128-bit matrix holds 16 signed bytes, row-major. Element a is [7:0], b is [15:8], and so on through p at [127:120]. The block passes it through unchanged.
- Reset values: state=IDLE, ptr=0, owner=0, gnt=0, eng_start=0, eng_mat=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, timeout counter=0.
- Reset mid-operation: returns to IDLE next cycle; no rsp_valid is produced for the in-flight job. The engine is assumed reset by the same rst.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching ptr, ptr+1, ... modulo NUM_REQ.
  - Same edge: eng_mat<=mat_in slice of winner, owner<=winner, gnt[winner]<=1, go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: gnt<=0, eng_start<=1, counter<=0, go to WAIT. eng_start is high for exactly one cycle.
- WAIT:
  - eng_start<=0. eng_done is sampled only in this state; done in any other state is ignored.
  - If eng_done: rsp_data<=eng_result, rsp_err<=0, go to RESP.
  - Else if counter==TIMEOUT_CYC-1: rsp_data<=0, rsp_err<=1, go to RESP.
  - Else counter increments.
  - If eng_done arrives on the timeout cycle, done wins (err=0).
- RESP: rsp_valid[owner]<=1 for one cycle, ptr<=(owner+1) mod NUM_REQ, go to IDLE.
- rsp_data and rsp_err hold their values until the next RESP.
- Latency:
  - req high in IDLE -> gnt 1 cycle later -> eng_start 2 cycles after req.
  - rsp_valid 2 cycles after eng_done.
  - Minimum back-to-back turnaround is 1 IDLE cycle between jobs.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 jobs.
- Requests that arrive while busy are not lost; they are seen in the next IDLE cycle because req is level-held.
- A requester dropping req before its gnt is allowed and is simply not granted.
- Only one job is in flight at a time; no queueing beyond the req levels.

Test Plan:
- Reset behaviour: hold rst 3 cycles with req=2'b11 -> all outputs 0, no gnt. Release -> gnt=2'b01 on the next edge.
- Identity matrix: req0 with the identity matrix (bytes a,f,k,p = 1, all others 0); model engine returns 16'sd1 with done 6 cycles after start.
  - Required: gnt[0] 1 cycle after req, eng_mat equals the identity matrix, eng_start one cycle.
  - Required: rsp_valid[0] with rsp_data=1, rsp_err=0 exactly 2 cycles after done.
- Simultaneous requests: req=2'b11 with matrices diag(2,3,4,5) (req0) and diag(-1,1,1,1) (req1).
  - Required: serviced in order 0 then 1, rsp_data=120 then -1.
  - Then req=2'b11 again -> ptr=0, so requester 0 is granted first again.
- Fairness: hold req=2'b11 continuously for 6 jobs -> gnt alternates 01,10,01,10,01,10.
- Timeout: engine never asserts done -> rsp_valid[owner] after exactly TIMEOUT_CYC WAIT cycles with rsp_err=1, rsp_data=0. The next request then proceeds normally.
- Reset mid-WAIT: assert rst one cycle during WAIT -> busy=0 next cycle and no rsp_valid. A later engine done pulse is ignored, and a new req is granted normally.

Source files
------------

// File: rtl/det_req_arbiter.sv
// det_req_arbiter: round-robin sharing of one 4x4 determinant engine between NUM_REQ requesters
module det_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*128-1:0]   mat_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     eng_start,
  output logic [127:0]             eng_mat,
  input  logic                     eng_done,
  input  logic signed [15:0]       eng_result,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic signed [15:0]       rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_winner;
  logic [PW-1:0] w_idx;
  logic          w_any;

  assign busy  = r_state != S_IDLE;
  assign w_any = |req;

  // scan downward from the farthest offset so the requester closest to ptr wins last
  always_comb begin
    w_winner = r_ptr;
    w_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = PW'((int'(r_ptr) + i) % NUM_REQ);
      if (req[w_idx]) w_winner = w_idx;
    end
  end

  // job sequencer: grant, launch, wait for done or timeout, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      gnt       <= '0;
      eng_start <= 1'b0;
      eng_mat   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      gnt       <= '0;
      eng_start <= 1'b0;
      rsp_valid <= '0;
      case (r_state)
        S_IDLE: if (w_any) begin
          eng_mat <= mat_in[{w_winner, 7'd0} +: 128];
          r_owner <= w_winner;
          gnt     <= NUM_REQ'(1) << w_winner;
          r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          eng_start <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: if (eng_done) begin
          rsp_data <= eng_result;
          rsp_err  <= 1'b0;
          r_state  <= S_RESP;
        end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
          r_state  <= S_RESP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          rsp_valid <= NUM_REQ'(1) << r_owner;
          r_ptr     <= r_owner == PW'(NUM_REQ - 1) ? '0 : r_owner + 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_det_req_arbiter.sv
// tb_det_req_arbiter: directed tests of the determinant engine arbiter with a delayed-done engine model
module tb_det_req_arbiter;
  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req;
  logic [255:0]       mat_in;
  logic [1:0]         gnt;
  logic               eng_start;
  logic [127:0]       eng_mat;
  logic               eng_done = 1'b0;
  logic signed [15:0] eng_result = '0;
  logic [1:0]         rsp_valid;
  logic signed [15:0] rsp_data;
  logic               rsp_err;
  logic               busy;
  int                 n_cmp = 0;
  int                 n_err = 0;
  bit                 eng_en = 1'b1;
  int                 ecnt = 0;
  logic [127:0]       m_id, m_d2345, m_dm1;

  det_req_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .req(req), .mat_in(mat_in), .gnt(gnt),
    .eng_start(eng_start), .eng_mat(eng_mat), .eng_done(eng_done),
    .eng_result(eng_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] diag(input int a, input int f, input int k, input int p);
    logic [127:0] m;
    m = '0;
    m[7:0]     = 8'(a);
    m[47:40]   = 8'(f);
    m[87:80]   = 8'(k);
    m[127:120] = 8'(p);
    return m;
  endfunction

  function automatic logic signed [15:0] diag_det(input logic [127:0] m);
    int r;
    r = int'($signed(m[7:0])) * int'($signed(m[47:40])) * int'($signed(m[87:80])) * int'($signed(m[127:120]));
    return 16'(r);
  endfunction

  // engine model: done pulse 6 cycles after the start cycle, result from the latched matrix diagonal
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (eng_start && eng_en) ecnt = 6;
    else if (ecnt > 0) begin
      ecnt = ecnt - 1;
      if (ecnt == 0) begin
        eng_done   = 1'b1;
        eng_result = diag_det(eng_mat);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic drain;
    int c;
    c = 0;
    while (c < 200) begin
      tick;
      if (!busy && rsp_valid == 2'b00 && gnt == 2'b00) break;
      c++;
    end
    n_cmp++; if (c >= 200) begin n_err++; $display("FAIL drain_timeout: busy=%b rsp_valid=%b required idle", busy, rsp_valid); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 2'b11;
    mat_in = {m_dm1, m_id};
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", gnt); end
      n_cmp++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", eng_start); end
      n_cmp++; if (eng_mat !== '0) begin n_err++; $display("FAIL rst_mat: got %h want 0", eng_mat); end
      n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
      n_cmp++; if (rsp_data !== 16'sd0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp: got %0d/%b want 0/0", rsp_data, rsp_err); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    end
    rst = 1'b0;
    tick;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rst_release_gnt: got %b want 01", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_release_busy: got %b want 1", busy); end
    req = 2'b00;
    drain;
  endtask

  task automatic test_identity;
    mat_in[127:0] = m_id;
    req = 2'b01;
    tick;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL id_gnt: got %b want 01", gnt); end
    n_cmp++; if (eng_mat !== m_id) begin n_err++; $display("FAIL id_mat: got %h want %h", eng_mat, m_id); end
    n_cmp++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL id_start_early: got %b want 0", eng_start); end
    req = 2'b00;
    tick;
    n_cmp++; if (eng_start !== 1'b1 || gnt !== 2'b00) begin n_err++; $display("FAIL id_start: got start=%b gnt=%b want 1/00", eng_start, gnt); end
    tick;
    n_cmp++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL id_start_width: got %b want 0", eng_start); end
    repeat (6) tick;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL id_rsp_early: got %b want 00", rsp_valid); end
    tick;
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL id_rsp_valid: got %b want 01", rsp_valid); end
    n_cmp++; if (rsp_data !== 16'sd1 || rsp_err !== 1'b0) begin n_err++; $display("FAIL id_rsp_data: got %0d/%b want 1/0", rsp_data, rsp_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL id_busy: got %b want 0", busy); end
    tick;
    n_cmp++; if (rsp_valid !== 2'b00 || rsp_data !== 16'sd1) begin n_err++; $display("FAIL id_rsp_hold: got %b/%0d want 00/1", rsp_valid, rsp_data); end
  endtask

  task automatic test_simultaneous;
    do_reset;
    mat_in = {m_dm1, m_d2345};
    req = 2'b11;
    tick;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL sim_gnt0: got %b want 01", gnt); end
    n_cmp++; if (eng_mat !== m_d2345) begin n_err++; $display("FAIL sim_mat0: got %h want %h", eng_mat, m_d2345); end
    req = 2'b10;
    repeat (8) tick;
    n_cmp++; if (rsp_valid !== 2'b00 || gnt !== 2'b00) begin n_err++; $display("FAIL sim_early: got rsp=%b gnt=%b want 00/00", rsp_valid, gnt); end
    tick;
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_data !== 16'sd120 || rsp_err !== 1'b0) begin n_err++; $display("FAIL sim_rsp0: got %b/%0d/%b want 01/120/0", rsp_valid, rsp_data, rsp_err); end
    tick;
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL sim_gnt1: got %b want 10", gnt); end
    n_cmp++; if (eng_mat !== m_dm1) begin n_err++; $display("FAIL sim_mat1: got %h want %h", eng_mat, m_dm1); end
    req = 2'b00;
    repeat (9) tick;
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== -16'sd1 || rsp_err !== 1'b0) begin n_err++; $display("FAIL sim_rsp1: got %b/%0d/%b want 10/-1/0", rsp_valid, rsp_data, rsp_err); end
    req = 2'b11;
    tick;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL sim_wrap_gnt: got %b want 01", gnt); end
    req = 2'b00;
    drain;
  endtask

  task automatic test_fairness;
    int got;
    logic [1:0] want;
    got = 0;
    do_reset;
    req = 2'b11;
    for (int c = 0; c < 200 && got < 6; c++) begin
      tick;
      if (gnt !== 2'b00) begin
        want = (got % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++; if (gnt !== want) begin n_err++; $display("FAIL fair_gnt%0d: got %b want %b", got, gnt, want); end
        got++;
        if (got == 6) req = 2'b00;
      end
    end
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL fair_count: got %0d grants want 6", got); end
    req = 2'b00;
    drain;
  endtask

  task automatic test_timeout;
    eng_en = 1'b0;
    req = 2'b01;
    tick;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL to_gnt: got %b want 01", gnt); end
    req = 2'b00;
    tick;
    n_cmp++; if (eng_start !== 1'b1) begin n_err++; $display("FAIL to_start: got %b want 1", eng_start); end
    repeat (64) tick;
    n_cmp++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL to_early: got rsp=%b busy=%b want 00/1", rsp_valid, busy); end
    tick;
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 16'sd0) begin n_err++; $display("FAIL to_rsp: got %b/%0d/%b want 01/0/1", rsp_valid, rsp_data, rsp_err); end
    eng_en = 1'b1;
    req = 2'b10;
    tick;
    n_cmp++; if (gnt !== 2'b10 || eng_mat !== m_dm1) begin n_err++; $display("FAIL to_next_gnt: got %b mat=%h want 10 mat=%h", gnt, eng_mat, m_dm1); end
    req = 2'b00;
    repeat (9) tick;
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== -16'sd1 || rsp_err !== 1'b0) begin n_err++; $display("FAIL to_next_rsp: got %b/%0d/%b want 10/-1/0", rsp_valid, rsp_data, rsp_err); end
  endtask

  task automatic test_reset_mid_wait;
    mat_in[127:0] = m_id;
    req = 2'b01;
    tick;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rmw_gnt: got %b want 01", gnt); end
    req = 2'b00;
    tick;
    n_cmp++; if (eng_start !== 1'b1) begin n_err++; $display("FAIL rmw_start: got %b want 1", eng_start); end
    repeat (2) tick;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmw_busy_wait: got %b want 1", busy); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || gnt !== 2'b00 || eng_start !== 1'b0) begin n_err++; $display("FAIL rmw_idle: got busy=%b gnt=%b start=%b want 0/00/0", busy, gnt, eng_start); end
    n_cmp++; if (eng_mat !== '0 || rsp_data !== 16'sd0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL rmw_regs: got mat=%h data=%0d err=%b want 0/0/0", eng_mat, rsp_data, rsp_err); end
    for (int i = 0; i < 8; i++) begin
      tick;
      n_cmp++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL rmw_quiet%0d: got rsp=%b busy=%b want 00/0", i, rsp_valid, busy); end
    end
    req = 2'b10;
    tick;
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rmw_new_gnt: got %b want 10", gnt); end
    req = 2'b00;
    repeat (9) tick;
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== -16'sd1 || rsp_err !== 1'b0) begin n_err++; $display("FAIL rmw_new_rsp: got %b/%0d/%b want 10/-1/0", rsp_valid, rsp_data, rsp_err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_id    = diag(1, 1, 1, 1);
    m_d2345 = diag(2, 3, 4, 5);
    m_dm1   = diag(-1, 1, 1, 1);
    test_reset;
    test_identity;
    test_simultaneous;
    test_fairness;
    test_timeout;
    test_reset_mid_wait;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
